// File: rtl/capture_pkt_sched.sv
// capture_pkt_sched: fills a capture buffer from the ADC (or from an internal
// counter in self-test), then streams the buffer to the pads in packets of
// PKT_LEN words separated by programmable idle gaps.
//   clk, rstn            : system clock, async active-low reset
//   cfg_*                : enable, soft reset, self-test, start, readout divider, gap length
//   adc_vld/adc_data     : sample input
//   mem_w*/mem_r*        : capture buffer write and read ports (read latency 1)
//   pad_data/valid/clk_rd: packet readout to pads
//   busy/done            : run status
module capture_pkt_sched #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 10,
  parameter int PKT_LEN = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_clk_en,
  input  logic              cfg_sw_rstn,
  input  logic              cfg_self_test_mode,
  input  logic              cfg_capture_start,
  input  logic [7:0]        cfg_clk_div,
  input  logic [7:0]        cfg_idle_length,
  input  logic              adc_vld,
  input  logic [DATA_W-1:0] adc_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pad_data,
  output logic              pad_valid,
  output logic              pad_clk_rd,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] PKT_MASK  = ADDR_W'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_PREFETCH, S_SEND, S_GAP, S_FIN
  } state_t;

  // All state lives in one packed record so that hard reset, soft reset and
  // the clock-enable hold act on every flop uniformly.
  typedef struct packed {
    state_t            state;
    logic              start;     // registered copy of cfg_capture_start
    logic [ADDR_W-1:0] wcnt;      // next capture address
    logic [DATA_W-1:0] st_cnt;    // self-test pattern counter
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        pf_phase;
    logic [DATA_W-1:0] prefetch;
    logic [DATA_W-1:0] pad_data;
    logic              pad_valid;
    logic              pad_clk;
    logic              done;
    logic [8:0]        cyc;       // cycle within the current readout step
    logic [7:0]        n;         // half-period latched at the step boundary
    logic [ADDR_W-1:0] word;      // address of the word on the pads
    logic [7:0]        gap_left;  // remaining gap steps
  } regs_t;

  regs_t             r_q, r_d;
  logic [7:0]        eff_n;
  logic [8:0]        cyc_nxt;
  logic              step_end;
  logic              advance;
  logic              begin_step;
  logic              begin_send;
  logic [ADDR_W-1:0] send_addr;

  always_comb begin
    r_d         = r_q;
    r_d.start   = cfg_capture_start;
    r_d.wen     = 1'b0;
    r_d.ren     = 1'b0;
    r_d.done    = 1'b0;
    eff_n       = (cfg_clk_div < 8'd2) ? 8'd2 : cfg_clk_div;
    cyc_nxt     = r_q.cyc + 9'd1;
    step_end    = (r_q.cyc == ({r_q.n, 1'b0} - 9'd1));
    advance     = 1'b0;
    begin_step  = 1'b0;
    begin_send  = 1'b0;
    send_addr   = r_q.word + 1'b1;

    case (r_q.state)
      S_IDLE: begin
        if (cfg_capture_start && !r_q.start) begin
          r_d.state  = S_CAPTURE;
          r_d.wcnt   = '0;
          r_d.st_cnt = '0;
        end
      end
      S_CAPTURE: begin
        if (adc_vld || cfg_self_test_mode) begin
          r_d.wen    = 1'b1;
          r_d.waddr  = r_q.wcnt;
          r_d.wdata  = cfg_self_test_mode ? r_q.st_cnt : adc_data;
          r_d.st_cnt = r_q.st_cnt + 1'b1;
          r_d.wcnt   = r_q.wcnt + 1'b1;
          if (r_q.wcnt == LAST_ADDR) begin
            r_d.state    = S_PREFETCH;
            r_d.ren      = 1'b1;
            r_d.raddr    = '0;
            r_d.pf_phase = 2'd0;
          end
        end
      end
      S_PREFETCH: begin
        // phase 0: read of address 0 on the bus, 1: data returns, 2: first word out
        case (r_q.pf_phase)
          2'd0: r_d.pf_phase = 2'd1;
          2'd1: begin
            r_d.prefetch = mem_rdata;
            r_d.pf_phase = 2'd2;
          end
          default: begin
            begin_send = 1'b1;
            send_addr  = '0;
          end
        endcase
      end
      S_SEND: begin
        if (r_q.cyc == 9'd1 && r_q.word != LAST_ADDR) r_d.prefetch = mem_rdata;
        if (step_end) begin
          if (r_q.word == LAST_ADDR) begin
            r_d.state     = S_FIN;
            r_d.pad_valid = 1'b0;
            r_d.pad_clk   = 1'b0;
            r_d.done      = 1'b1;
          end else if ((r_q.word & PKT_MASK) == PKT_MASK && cfg_idle_length != '0) begin
            r_d.state     = S_GAP;
            r_d.pad_valid = 1'b0;
            r_d.gap_left  = cfg_idle_length;
            begin_step    = 1'b1;
          end else begin
            begin_send = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      S_GAP: begin
        if (step_end) begin
          if (r_q.gap_left == 8'd1) begin
            begin_send = 1'b1;
          end else begin
            r_d.gap_left = r_q.gap_left - 8'd1;
            begin_step   = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      S_FIN:   r_d.state = S_IDLE;
      default: r_d.state = S_IDLE;
    endcase

    if (advance) begin
      r_d.cyc     = cyc_nxt;
      r_d.pad_clk = (cyc_nxt >= {1'b0, r_q.n});
    end
    if (begin_step || begin_send) begin
      r_d.cyc     = '0;
      r_d.n       = eff_n;
      r_d.pad_clk = 1'b0;
    end
    // Word already sits in the prefetch register; the read issued here
    // refills it for the following step.
    if (begin_send) begin
      r_d.state     = S_SEND;
      r_d.word      = send_addr;
      r_d.pad_data  = r_q.prefetch;
      r_d.pad_valid = 1'b1;
      r_d.ren       = (send_addr != LAST_ADDR);
      r_d.raddr     = send_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (!cfg_sw_rstn) begin
      r_q <= '0;
    end else if (cfg_clk_en) begin
      r_q <= r_d;
    end
  end

  assign mem_wen    = r_q.wen;
  assign mem_waddr  = r_q.waddr;
  assign mem_wdata  = r_q.wdata;
  assign mem_ren    = r_q.ren;
  assign mem_raddr  = r_q.raddr;
  assign pad_data   = r_q.pad_data;
  assign pad_valid  = r_q.pad_valid;
  assign pad_clk_rd = r_q.pad_clk;
  assign busy       = (r_q.state != S_IDLE);
  assign done       = r_q.done;

endmodule

// File: tb/tb_capture_pkt_sched.sv
module tb_capture_pkt_sched;

  localparam int DATA_W  = 18;
  localparam int ADDR_W  = 10;
  localparam int PKT_LEN = 64;
  localparam int DEPTH   = 1024;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_clk_en = 1'b1;
  logic              cfg_sw_rstn = 1'b1;
  logic              cfg_self_test_mode = 1'b0;
  logic              cfg_capture_start = 1'b0;
  logic [7:0]        cfg_clk_div = 8'd8;
  logic [7:0]        cfg_idle_length = 8'd0;
  logic              adc_vld = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pad_data;
  logic              pad_valid;
  logic              pad_clk_rd;
  logic              busy;
  logic              done;

  capture_pkt_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rstn(rstn), .cfg_clk_en(cfg_clk_en), .cfg_sw_rstn(cfg_sw_rstn),
    .cfg_self_test_mode(cfg_self_test_mode), .cfg_capture_start(cfg_capture_start),
    .cfg_clk_div(cfg_clk_div), .cfg_idle_length(cfg_idle_length),
    .adc_vld(adc_vld), .adc_data(adc_data),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .pad_data(pad_data), .pad_valid(pad_valid), .pad_clk_rd(pad_clk_rd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous buffer: read data appears one cycle after mem_ren and holds.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [DATA_W-1:0] exp_q[$];
  int cur_n = 2;
  int cur_idle = 0;
  int words_seen = 0;
  int done_seen = 0;

  logic en_at_edge = 1'b0;
  always @(posedge clk) en_at_edge <= cfg_clk_en;

  // Output monitor: pops expected words, checks word hold, gap length and
  // readout clock period in enabled cycles only.
  logic prev_valid = 1'b0, prev_clk = 1'b0, prev_done = 1'b0;
  int   run_words = 0, hold_cnt = 0, gap_cnt = 0, act_cyc = 0, last_rise = -1;
  always @(negedge clk) begin
    if (rstn && en_at_edge) begin
      act_cyc++;
      if (!busy) begin
        check("idle_pad_clk", pad_clk_rd, 0);
        check("idle_pad_valid", pad_valid, 0);
        run_words = 0; hold_cnt = 0; gap_cnt = 0; last_rise = -1;
      end else begin
        automatic logic new_word = pad_valid && (!prev_valid || (prev_clk && !pad_clk_rd));
        if (prev_valid && (new_word || !pad_valid)) begin
          check("hold", hold_cnt, 2 * cur_n);
          hold_cnt = 0;
        end
        if (new_word) begin
          if (run_words > 0)
            check("gap", gap_cnt, (run_words % PKT_LEN == 0) ? cur_idle * 2 * cur_n : 0);
          gap_cnt = 0;
          if (exp_q.size() == 0) check("extra_word", 1, 0);
          else check("pad_data", pad_data, exp_q.pop_front());
          run_words++;
          words_seen++;
        end
        if (pad_valid) hold_cnt++;
        else if (run_words > 0) gap_cnt++;
        if (pad_clk_rd && !prev_clk) begin
          if (last_rise >= 0) check("clk_period", act_cyc - last_rise, 2 * cur_n);
          last_rise = act_cyc;
        end
      end
      if (done) begin
        done_seen++;
        check("done_busy", busy, 1);
        check("done_single", prev_done, 0);
      end
      prev_valid = pad_valid;
      prev_clk   = pad_clk_rd;
      prev_done  = done;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wen"}, mem_wen, 0);
    check({tag, "_ren"}, mem_ren, 0);
    check({tag, "_raddr"}, mem_raddr, 0);
    check({tag, "_pad_data"}, pad_data, 0);
    check({tag, "_pad_valid"}, pad_valid, 0);
    check({tag, "_pad_clk"}, pad_clk_rd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic start_run(input bit self_test, input int n_div, input int idle);
    @(negedge clk);
    cfg_self_test_mode = self_test;
    cfg_clk_div        = 8'(n_div);
    cfg_idle_length    = 8'(idle);
    cur_n              = (n_div < 2) ? 2 : n_div;
    cur_idle           = idle;
    if (self_test)
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(DATA_W'(i));
    cfg_capture_start = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    check("start_busy", busy, 1);
    cfg_capture_start = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int i = 0; i < budget && words_seen < target; i++) @(negedge clk);
    check("words_timeout", words_seen >= target, 1);
  endtask

  task automatic wait_gap(input int budget);
    for (int i = 0; i < budget && !(busy && !pad_valid); i++) @(negedge clk);
    check("gap_timeout", busy && !pad_valid, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_seen < target; i++) @(negedge clk);
    check("done_timeout", done_seen >= target, 1);
    repeat (20) @(negedge clk);
    check("done_count", done_seen, target);
    check("queue_empty", exp_q.size(), 0);
    check("idle_after_run", busy, 0);
  endtask

  initial begin
    logic [63:0] snap;
    logic [DATA_W-1:0] snap_data;
    int cnt;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Self-test, N=8, 15 idle steps between packets.
    start_run(1'b1, 8, 15);
    wait_done(1, 40000);

    // ADC capture, divider 0 (treated as 2), no gaps, extra start edges ignored.
    start_run(1'b0, 0, 0);
    cnt = 0;
    while (cnt < DEPTH) begin
      adc_vld  = ($urandom_range(0, 3) != 0);
      adc_data = DATA_W'($urandom);
      if (adc_vld) begin
        exp_q.push_back(adc_data);
        cnt++;
      end
      if (cnt == 300) cfg_capture_start = 1'b1;
      @(negedge clk);
    end
    adc_vld = 1'b0;
    cfg_capture_start = 1'b0;
    wait_words(words_seen + 100, 2000);
    cfg_capture_start = 1'b1;
    @(negedge clk);
    cfg_capture_start = 1'b0;
    wait_done(2, 10000);

    // Clock-enable freeze mid-SEND.
    start_run(1'b1, 3, 2);
    wait_words(words_seen + 150, 4000);
    @(posedge clk);
    #1 cfg_clk_en = 1'b0;
    @(negedge clk);
    snap      = {mem_wen, mem_ren, mem_raddr, pad_valid, pad_clk_rd, busy, done};
    snap_data = pad_data;
    check("freeze_in_send", pad_valid, 1);
    repeat (100) @(negedge clk);
    check("freeze_ctrl", {mem_wen, mem_ren, mem_raddr, pad_valid, pad_clk_rd, busy, done}, snap);
    check("freeze_data", pad_data, snap_data);
    cfg_clk_en = 1'b1;
    wait_done(3, 12000);

    // Hard reset during GAP.
    start_run(1'b1, 2, 1);
    wait_words(words_seen + PKT_LEN, 4000);
    wait_gap(100);
    rstn = 1'b0;
    #2 check_zero_outputs("rstn_gap");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check_zero_outputs("after_rstn");
    check("rstn_no_done", done_seen, 3);

    // Soft reset during GAP, with the clock enable low to show it wins.
    start_run(1'b1, 2, 1);
    wait_words(words_seen + PKT_LEN, 4000);
    wait_gap(100);
    cfg_sw_rstn = 1'b0;
    cfg_clk_en  = 1'b0;
    @(negedge clk);
    check_zero_outputs("sw_rst_gap");
    cfg_sw_rstn = 1'b1;
    cfg_clk_en  = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("sw_rst_no_done", done_seen, 3);

    // Fresh complete run after the aborts.
    start_run(1'b1, 2, 1);
    wait_done(4, 8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
